// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-port memory among NUM_REQ requesters,
// with fixed or round-robin priority, anti-starvation and in-flight read tracking.

module mem_port_arbiter_wait_cnt #(
   parameter int MAX_WAIT = 8,
   parameter bit ENABLE   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic ready,
   output logic starved
);
   localparam int  CNT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam bit  CNT_EN  = ENABLE && (MAX_WAIT > 0);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !CNT_EN) begin
         cnt <= '0;
      end else if (!valid || ready) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign starved = CNT_EN && (cnt == CNT_MAX);
endmodule

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_REQ    = 2,
   parameter int PRIO_MODE  = 0,
   parameter int RD_LATENCY = 1,
   parameter int MAX_WAIT   = 8,
   localparam int BE_W      = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*BE_W-1:0]   req_be,
   input  logic [NUM_REQ-1:0]        req_flush,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [BE_W-1:0]           mem_be,
   input  logic [DATA_W-1:0]         mem_rdata
);
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int STAGES = RD_LATENCY - 1;

   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] starved;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   rr_ptr;
   logic               found;
   logic               rd_issue;
   logic               tail_vld;

   logic [STAGES:0]            vld_pipe;
   logic [STAGES:0][IDX_W-1:0] id_pipe;

   // Per-requester starvation counters; they only run in fixed-priority mode.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
      mem_port_arbiter_wait_cnt #(
         .MAX_WAIT (MAX_WAIT),
         .ENABLE   (PRIO_MODE == 0)
      ) u_wait (
         .clk     (clk),
         .rst     (rst),
         .valid   (req_valid[g]),
         .ready   (grant[g]),
         .starved (starved[g])
      );
   end

   always_comb begin
      grant = '0;
      found = 1'b0;
      if (!rst) begin
         if (PRIO_MODE == 0) begin
            // Starved requesters outrank normal priority, lowest index first.
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!found && req_valid[i] && starved[i]) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
               if (!found && req_valid[i]) begin
                  grant[i] = 1'b1;
                  found    = 1'b1;
               end
            end
         end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               int idx;
               idx = (int'(rr_ptr) + k) % NUM_REQ;
               if (!found && req_valid[idx]) begin
                  grant[idx] = 1'b1;
                  found      = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) gnt_idx = IDX_W'(i);
      end
   end

   assign req_ready = grant;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (|grant) begin
         mem_en   = 1'b1;
         mem_we   = req_we[gnt_idx];
         mem_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
         if (req_we[gnt_idx]) begin
            mem_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
            mem_be    = req_be[gnt_idx*BE_W +: BE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= IDX_W'(NUM_REQ - 1);
      end else if (|grant) begin
         rr_ptr <= gnt_idx;
      end
   end

   assign rd_issue = mem_en && !mem_we;

   // A read entering stage 0 is never flushed in its issue cycle; older
   // entries are dropped as they advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= rd_issue;
         id_pipe[0]  <= gnt_idx;
         for (int s = 1; s <= STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1] && !req_flush[id_pipe[s-1]];
            id_pipe[s]  <= id_pipe[s-1];
         end
      end
   end

   assign tail_vld = !rst && vld_pipe[STAGES] && !req_flush[id_pipe[STAGES]];

   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (tail_vld) begin
         rsp_valid[id_pipe[STAGES]] = 1'b1;
         rsp_data                   = mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority instance (latency 1) and a
// round-robin instance (latency 2), read responses tracked in a scoreboard.

module tb_mem_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req_valid [2];
   logic [1:0]  req_ready [2];
   logic [1:0]  req_we    [2];
   logic [1:0]  req_flush [2];
   logic [1:0]  rsp_valid [2];
   logic [63:0] req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [7:0]  req_be    [2];
   logic [31:0] rsp_data  [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [3:0]  mem_be    [2];

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .NUM_REQ(2), .PRIO_MODE(0), .RD_LATENCY(1), .MAX_WAIT(3)
   ) u_fix (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_we(req_we[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]), .req_flush(req_flush[0]),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]), .mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .NUM_REQ(2), .PRIO_MODE(1), .RD_LATENCY(2), .MAX_WAIT(3)
   ) u_rr (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_we(req_we[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]), .req_flush(req_flush[1]),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   function automatic int lat(input int u);
      return (u == 0) ? 1 : 2;
   endfunction

   // Memory stand-in: read data appears RD_LATENCY cycles after the access.
   logic [31:0] m0, m1a, m1b;
   always @(posedge clk) begin
      m0  <= (mem_en[0] && !mem_we[0]) ? mem_f(mem_addr[0]) : 32'h0;
      m1a <= (mem_en[1] && !mem_we[1]) ? mem_f(mem_addr[1]) : 32'h0;
      m1b <= m1a;
   end
   assign mem_rdata[0] = m0;
   assign mem_rdata[1] = m1b;

   typedef struct {
      int          u;
      int          due;
      int          id;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc, chk_cnt, pass_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_rsp(input string tag);
      for (int u = 0; u < 2; u++) begin
         logic [1:0]  ev;
         logic [31:0] ed;
         ev = '0;
         ed = '0;
         for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].u == u && sb[i].due == cyc) begin
               ev = 2'b01 << sb[i].id;
               ed = sb[i].data;
            end
         end
         chk($sformatf("%s/rsp%0d", tag, u), 64'({rsp_valid[u], rsp_data[u]}), 64'({ev, ed}));
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) sb.delete(i);
      end
   endtask

   // Inputs are already driven; checks the combinational grant/memory view,
   // books any read into the scoreboard, checks responses, then advances.
   task automatic step(input int u, input logic [1:0] exp_rdy, input string tag);
      int          id;
      logic        w;
      logic [31:0] a;
      #1;
      for (int f = 0; f < 2; f++) begin
         if (req_flush[u][f]) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
               if (sb[i].u == u && sb[i].id == f && sb[i].due >= cyc && sb[i].due < cyc + lat(u))
                  sb.delete(i);
            end
         end
      end
      chk({tag, "/ready"}, 64'(req_ready[u]), 64'(exp_rdy));
      if (exp_rdy != 2'b00) begin
         id = exp_rdy[1] ? 1 : 0;
         a  = req_addr[u][id*32 +: 32];
         w  = req_we[u][id];
         chk({tag, "/mem_ctl"}, 64'({mem_en[u], mem_we[u], mem_be[u]}),
             64'({1'b1, w, w ? req_be[u][id*4 +: 4] : 4'h0}));
         chk({tag, "/mem_aw"}, {mem_addr[u], mem_wdata[u]},
             {a, w ? req_wdata[u][id*32 +: 32] : 32'h0});
         if (!w) sb.push_back('{u, cyc + lat(u), id, mem_f(a)});
      end else begin
         chk({tag, "/mem_ctl"}, 64'({mem_en[u], mem_we[u], mem_be[u]}), 64'h0);
         chk({tag, "/mem_aw"}, {mem_addr[u], mem_wdata[u]}, 64'h0);
      end
      check_rsp(tag);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; chk_cnt = 0; pass_cnt = 0;
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = '0; req_we[u] = '0; req_flush[u] = '0;
         req_addr[u] = '0; req_wdata[u] = '0; req_be[u] = '0;
      end
      @(negedge clk);
      step(0, 2'b00, "rst_fix");
      step(1, 2'b00, "rst_rr");
      rst = 1'b0;

      // Single fetch read, data returns next cycle
      req_valid[0] = 2'b01; req_addr[0] = {32'h0, 32'h100};
      step(0, 2'b01, "t1_rd");
      req_valid[0] = 2'b00;
      step(0, 2'b00, "t1_rsp");

      // Contention under fixed priority: data wins 3 cycles, fetch forced on the 4th
      req_valid[0] = 2'b11; req_addr[0] = {32'h20, 32'h10};
      for (int r = 0; r < 2; r++) begin
         step(0, 2'b10, "t2_d0");
         step(0, 2'b10, "t2_d1");
         step(0, 2'b10, "t2_d2");
         step(0, 2'b01, "t2_f");
      end

      // Posted write: no response follows
      req_valid[0] = 2'b10; req_we[0] = 2'b10; req_addr[0] = {32'h200, 32'h0};
      req_wdata[0] = {32'h55, 32'h0}; req_be[0] = {4'b0001, 4'b0000};
      step(0, 2'b10, "t4_wr");
      req_valid[0] = 2'b00; req_we[0] = 2'b00;
      step(0, 2'b00, "t4_post0");
      step(0, 2'b00, "t4_post1");

      // Round-robin alternation, requester 0 first after reset
      req_valid[1] = 2'b11; req_addr[1] = {32'h44, 32'h40};
      step(1, 2'b01, "t3_g0");
      step(1, 2'b10, "t3_g1");
      step(1, 2'b01, "t3_g2");
      step(1, 2'b10, "t3_g3");
      req_valid[1] = 2'b00;
      step(1, 2'b00, "t3_drain0");
      step(1, 2'b00, "t3_drain1");

      // Flush the cycle after two reads: both responses vanish
      req_valid[1] = 2'b01; req_addr[1] = {32'h0, 32'hA0};
      step(1, 2'b01, "t5_a");
      req_addr[1] = {32'h0, 32'hB0};
      step(1, 2'b01, "t5_b");
      req_valid[1] = 2'b00; req_flush[1] = 2'b01;
      step(1, 2'b00, "t5_flush");
      req_flush[1] = 2'b00;
      step(1, 2'b00, "t5_q0");
      step(1, 2'b00, "t5_q1");

      // Flush in the same cycle as the grant does not kill that read
      req_valid[1] = 2'b01; req_flush[1] = 2'b01; req_addr[1] = {32'h0, 32'hC0};
      step(1, 2'b01, "t5_same");
      req_valid[1] = 2'b00; req_flush[1] = 2'b00;
      step(1, 2'b00, "t5_same_w");
      step(1, 2'b00, "t5_same_r");

      // Flushing another requester leaves this read alone
      req_valid[1] = 2'b01; req_addr[1] = {32'h0, 32'hD0};
      step(1, 2'b01, "t5_other");
      req_valid[1] = 2'b00; req_flush[1] = 2'b10;
      step(1, 2'b00, "t5_other_f");
      req_flush[1] = 2'b00;
      step(1, 2'b00, "t5_other_r");

      // Reset with reads in flight; pointer returns to requester 0 first
      req_valid[1] = 2'b01; req_addr[1] = {32'h0, 32'hE0};
      step(1, 2'b01, "t6_a");
      req_addr[1] = {32'h0, 32'hE4};
      step(1, 2'b01, "t6_b");
      req_valid[1] = 2'b00; rst = 1'b1;
      sb.delete();
      step(1, 2'b00, "t6_rst");
      rst = 1'b0;
      step(1, 2'b00, "t6_q0");
      step(1, 2'b00, "t6_q1");
      req_valid[1] = 2'b11; req_addr[1] = {32'hF4, 32'hF0};
      step(1, 2'b01, "t6_n0");
      step(1, 2'b10, "t6_n1");
      req_valid[1] = 2'b00;
      step(1, 2'b00, "t6_r0");
      step(1, 2'b00, "t6_r1");
      step(1, 2'b00, "t6_r2");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
